hist_queue: RTL and testbench

Parametrised shift-history queue, the successor to the fixed 8-entry, 4-bit shift queue. It is fully synchronous on `clock` and detects the insert strobe's rising edge internally. Beyond the two oldest-entry outputs it adds valid tracking, an occupancy count with full/empty, synchronous clear, and a random-access read port. It sits between the game controller, which inserts each new symbol, and the comparison/display logic, which reads back the history.

---
 rtl/histq_pkg.sv | 19 +
 rtl/edge_rise_det.sv | 21 ++
 rtl/hist_queue.sv | 88 ++++++++
 tb/tb_hist_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/histq_pkg.sv
// Shared defaults and width helpers for the shift-history queue.
// Also holds the reset value of the insert-strobe history register.
package histq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  // Held high in reset so a strobe already high at release is not taken as an insert.
  localparam logic WRITE_PREV_RST = 1'b1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for the insert strobe.
// Registers the strobe and produces a one-cycle pulse on each 0->1 transition.
module edge_rise_det
  import histq_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic sig,
  output logic pulse
);

  logic sig_prev;

  always_ff @(posedge clock) begin
    if (!reset_n) sig_prev <= WRITE_PREV_RST;
    else          sig_prev <= sig;
  end

  assign pulse = sig & ~sig_prev;

endmodule

// File: rtl/hist_queue.sv
// Parametrised shift-history queue with valid tracking, occupancy and random read.
// Optional feature: define HISTQ_MATCH_EN to add the registered `match` flag.
module hist_queue
  import histq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = cnt_w(DEPTH),
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
`ifdef HISTQ_MATCH_EN
  ,
  output logic              match
`endif
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              push;

  edge_rise_det u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (write),
    .pulse   (push)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else if (push) begin
      data_q[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
      valid_q <= {valid_q[DEPTH-2:0], 1'b1};
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end
  end

  // Decoded by loop so out-of-range addresses (non power-of-2 DEPTH) fall through to 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ADDR_W'(i) == rd_addr && valid_q[i]) rd_data = data_q[i];
    end
  end

  assign data_out1  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
  assign data_out2  = valid_q[DEPTH-2] ? data_q[DEPTH-2] : '0;
  assign valid_out1 = valid_q[DEPTH-1];
  assign valid_out2 = valid_q[DEPTH-2];
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

`ifdef HISTQ_MATCH_EN
  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && data_q[i] == data_in) hit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) match <= 1'b0;
    else if (push)         match <= hit;
  end
`endif

endmodule

// File: tb/tb_hist_queue.sv
// Directed bench for hist_queue: DEPTH=8 main instance plus a DEPTH=5 instance
// sharing the same insert/clear stimulus. Match checks run with HISTQ_MATCH_EN.
module tb_hist_queue;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] data_in;
  logic       write;
  logic       clear;
  logic [2:0] rd_addr;
  logic [2:0] rd_addr5;

  logic [3:0] rd_data, data_out1, data_out2;
  logic       valid_out1, valid_out2, full, empty;
  logic [3:0] count;

  logic [3:0] rd_data5, data_out1_5, data_out2_5;
  logic       valid_out1_5, valid_out2_5, full5, empty5;
  logic [2:0] count5;

`ifdef HISTQ_MATCH_EN
  logic match, match5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hist_queue #(.DATA_W(4), .DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .write(write),
    .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_out1(data_out1), .data_out2(data_out2),
    .valid_out1(valid_out1), .valid_out2(valid_out2),
    .count(count), .full(full), .empty(empty)
`ifdef HISTQ_MATCH_EN
    , .match(match)
`endif
  );

  hist_queue #(.DATA_W(4), .DEPTH(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .write(write),
    .clear(clear), .rd_addr(rd_addr5), .rd_data(rd_data5),
    .data_out1(data_out1_5), .data_out2(data_out2_5),
    .valid_out1(valid_out1_5), .valid_out2(valid_out2_5),
    .count(count5), .full(full5), .empty(empty5)
`ifdef HISTQ_MATCH_EN
    , .match(match5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe high for 3 cycles then low for 1; checks happen on the falling edge.
  task automatic push(input logic [3:0] v);
    @(negedge clock);
    data_in = v;
    write   = 1'b1;
    repeat (3) @(negedge clock);
    write = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    data_in  = 4'h0;
    write    = 1'b1;
    clear    = 1'b0;
    rd_addr  = 3'd0;
    rd_addr5 = 3'd6;

    // Reset with write held high through release: no insert.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out1", data_out1, 0);
    chk("rst_out2", data_out2, 0);
    chk("rst_valid1", valid_out1, 0);
    chk("rst_rd", rd_data, 0);
    write = 1'b0;
    @(negedge clock);

    for (int v = 1; v <= 8; v++) begin
      push(4'(v));
      chk($sformatf("count_%0d", v), count, 32'(v));
      if (v == 2) begin
        chk("d5_valid1", valid_out1_5, 0);
        chk("d5_out1", data_out1_5, 0);
        chk("d5_out2", data_out2_5, 0);
        chk("d5_count", count5, 2);
      end
      if (v == 7) chk("not_full_7", full, 0);
    end
    chk("full_8", full, 1);
    chk("empty_8", empty, 0);
    chk("out1_8", data_out1, 1);
    chk("out2_8", data_out2, 2);
    chk("valid1_8", valid_out1, 1);
    chk("rd0_8", rd_data, 8);
    rd_addr = 3'd3;
    #1 chk("rd3_8", rd_data, 5);
    chk("d5_rd6", rd_data5, 0);
    chk("d5_out1_full", data_out1_5, 4);
    chk("d5_count_sat", count5, 5);
    chk("d5_full", full5, 1);
    rd_addr5 = 3'd4;
    #1 chk("d5_rd4", rd_data5, 4);

    push(4'd9);
    chk("out1_9", data_out1, 2);
    chk("out2_9", data_out2, 3);
    chk("count_9", count, 8);
    rd_addr = 3'd0;
    #1 chk("rd0_9", rd_data, 9);

    // Clear coincident with a write rising edge; strobe then held 2 more cycles.
    @(negedge clock);
    data_in = 4'd7;
    write   = 1'b1;
    clear   = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (2) @(negedge clock);
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_out1", data_out1, 0);
    chk("clr_out2", data_out2, 0);
    chk("clr_rd0", rd_data, 0);
    write = 1'b0;
    @(negedge clock);

    // Push latency: new contents visible right after the sampling edge.
    data_in = 4'd5;
    write   = 1'b1;
    @(posedge clock);
    #1;
    chk("lat_count", count, 1);
    chk("lat_rd0", rd_data, 5);
    @(negedge clock);
    write = 1'b0;
    @(negedge clock);

    push(4'd6);
    chk("mid_count", count, 2);
    do_reset();
    @(negedge clock);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd0", rd_data, 0);

`ifdef HISTQ_MATCH_EN
    chk("m_rst", match, 0);
    push(4'hA);
    chk("m_a", match, 0);
    push(4'hB);
    chk("m_b", match, 0);
    push(4'hA);
    chk("m_aa", match, 1);
    push(4'hC);
    chk("m_c", match, 0);
    push(4'hB);
    chk("m_bb", match, 1);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("m_clr", match, 0);
    push(4'h0);
    chk("m_zero_invalid", match, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
